// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared constants, state encoding and shift-count helper for the float/fixed converters
//
// Shared by float_to_fixed and the fixed-to-float normalizer.
//   MW_DEF / EW_DEF : default mantissa and exponent widths
//   conv_state_t    : IDLE / SHIFT / DONE
//   calc_shift()    : maps exponent P to right-shift count n = (mw-1) - P,
//                     flagging exponents that exceed mw-1

package float_pkg;

    localparam int MW_DEF = 4;
    localparam int EW_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    typedef struct packed {
        logic       err;
        logic [7:0] n;
    } shift_req_t;

    // An out-of-range exponent reports err with n forced to 0, so callers
    // never see a wrapped count.
    function automatic shift_req_t calc_shift(input int unsigned mw, input int unsigned p);
        shift_req_t r;
        if (p > mw - 1) begin
            r.err = 1'b1;
            r.n   = 8'd0;
        end else begin
            r.err = 1'b0;
            r.n   = 8'(mw - 1 - p);
        end
        return r;
    endfunction

endpackage

// File: rtl/float_to_fixed.sv
// rtl/float_to_fixed.sv - iterative float (F,P) to unsigned fixed-point converter, one shift per clock
//
// Restores D = F >> ((MW-1) - P).
// Ports:
//   sysClk       in   clock, rising edge
//   sysRst       in   synchronous active-low reset
//   in_valid     in   F/P presented
//   in_ready     out  accepting input (decode of IDLE)
//   F            in   MW-bit mantissa
//   P            in   EW-bit exponent
//   out_valid    out  D and flags valid (decode of DONE)
//   out_ready    in   consumer takes the result
//   D            out  MW-bit fixed-point result
//   out_inexact  out  a 1-bit was shifted out
//   out_err      out  P > MW-1

module float_to_fixed
    import float_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic          sysClk,
    input  logic          sysRst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] F,
    input  logic [EW-1:0] P,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] D,
    output logic          out_inexact,
    output logic          out_err
);

    localparam int CW = $clog2(MW) + 1;

    conv_state_t   state_q, state_d;
    logic [MW-1:0] work_q, work_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] d_q, d_d;
    logic          inexact_q, inexact_d;
    logic          err_q, err_d;
    shift_req_t    req;

    always_ff @(posedge sysClk) begin
        if (!sysRst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            d_q       <= '0;
            inexact_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            inexact_q <= inexact_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        inexact_d = inexact_q;
        err_d     = err_q;
        req       = calc_shift(MW, 32'(P));

        case (state_q)
            IDLE: begin
                // in_ready is the IDLE decode, so in_valid alone means a handshake here.
                if (in_valid) begin
                    work_d    = F;
                    inexact_d = 1'b0;
                    err_d     = 1'b0;
                    if (req.err) begin
                        d_d     = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (req.n == 8'd0) begin
                        d_d     = F;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CW'(req.n);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d    = {1'b0, work_q[MW-1:1]};
                inexact_d = inexact_q | work_q[0];
                cnt_d     = cnt_q - 1'b1;
                // Last shift: publish the shifted value on the same edge.
                if (cnt_q == CW'(1)) begin
                    d_d     = {1'b0, work_q[MW-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign D           = d_q;
    assign out_inexact = inexact_q;
    assign out_err     = err_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// tb/tb_float_to_fixed.sv - self-checking bench for float_to_fixed

module tb_float_to_fixed;

    logic       sysClk;
    logic       sysRst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] F;
    logic [1:0] P;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] D;
    logic       out_inexact;
    logic       out_err;

    int n_checks = 0;
    int n_fail   = 0;

    float_to_fixed #(.MW(4), .EW(2)) dut (
        .sysClk      (sysClk),
        .sysRst      (sysRst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .F           (F),
        .P           (P),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .D           (D),
        .out_inexact (out_inexact),
        .out_err     (out_err)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the original value is F divided by 2^n, truncated;
    // anything lost in the division makes the result inexact.
    task automatic model(input int f, input int p,
                         output int d, output int inx, output int err, output int lat);
        int n;
        if (p > 3) begin
            d = 0; inx = 0; err = 1; lat = 0;
        end else begin
            n   = 3 - p;
            d   = f / (2 ** n);
            inx = ((f % (2 ** n)) != 0) ? 1 : 0;
            err = 0;
            lat = n;
        end
    endtask

    // Presents one operand pair, waits for the result and checks value,
    // flags and latency. With out_ready high it also checks the return to IDLE.
    task automatic convert(input string tag, input logic [3:0] f, input logic [1:0] p);
        int ed, einx, eerr, elat, lat;
        model(int'(f), int'(p), ed, einx, eerr, elat);
        @(negedge sysClk);
        F = f; P = p; in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge sysClk);
        @(negedge sysClk);
        in_valid = 1'b0;
        F = 4'($urandom);
        P = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge sysClk);
            @(negedge sysClk);
            lat++;
        end
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(elat));
        chk({tag, ".D"}, 32'(D), 32'(ed));
        chk({tag, ".inexact"}, 32'(out_inexact), 32'(einx));
        chk({tag, ".err"}, 32'(out_err), 32'(eerr));
        if (out_ready) begin
            @(posedge sysClk);
            @(negedge sysClk);
            chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
            chk({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [3:0] hd;
        logic       hi, he;

        sysRst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; F = '0; P = '0;
        repeat (2) @(posedge sysClk);
        @(negedge sysClk);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.D", 32'(D), 32'd0);
        chk("rst.inexact", 32'(out_inexact), 32'd0);
        chk("rst.err", 32'(out_err), 32'd0);
        sysRst = 1'b1;

        // Directed vectors
        convert("v1010p2", 4'b1010, 2'd2);
        convert("v1110p2", 4'b1110, 2'd2);
        convert("v1100p1", 4'b1100, 2'd1);
        convert("v1000p0", 4'b1000, 2'd0);
        convert("v1011p3", 4'b1011, 2'd3);
        convert("v1011p1", 4'b1011, 2'd1);
        convert("v0000p0", 4'b0000, 2'd0);

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        convert("bp", 4'b1011, 2'd1);
        hd = D; hi = out_inexact; he = out_err;
        for (int i = 0; i < 5; i++) begin
            F = 4'($urandom); P = 2'($urandom); in_valid = ~in_valid;
            @(posedge sysClk);
            @(negedge sysClk);
            chk("bp.D", 32'(D), 32'b0010);
            chk("bp.hold", 32'({D, out_inexact, out_err}), 32'({hd, hi, he}));
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            chk("bp.out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge sysClk);
        @(negedge sysClk);
        chk("bp.release_ready", 32'(in_ready), 32'd1);
        chk("bp.release_valid", 32'(out_valid), 32'd0);

        // Reset mid-SHIFT: no result, all outputs back to reset values
        F = 4'b1000; P = 2'd0; in_valid = 1'b1;
        @(posedge sysClk);
        @(negedge sysClk);
        chk("mid.in_shift", 32'(in_ready), 32'd0);
        sysRst = 1'b0;
        @(posedge sysClk);
        @(negedge sysClk);
        chk("mid.out_valid", 32'(out_valid), 32'd0);
        chk("mid.D", 32'(D), 32'd0);
        chk("mid.inexact", 32'(out_inexact), 32'd0);
        chk("mid.err", 32'(out_err), 32'd0);
        chk("mid.in_ready", 32'(in_ready), 32'd1);
        @(posedge sysClk);
        @(negedge sysClk);
        chk("mid.no_capture", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        sysRst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge sysClk);
            @(negedge sysClk);
            chk("mid.no_pulse", 32'(out_valid), 32'd0);
        end
        convert("after_rst", 4'b1110, 2'd1);

        // Back-to-back with out_ready tied high
        convert("b2b0", 4'b1001, 2'd0);
        convert("b2b1", 4'b1101, 2'd1);
        convert("b2b2", 4'b1111, 2'd2);
        convert("b2b3", 4'b1010, 2'd3);

        // Random operands, normalized or not
        for (int i = 0; i < 24; i++) begin
            convert("rand", 4'($urandom), 2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
